eth_crc_frame_ctrl: RTL and testbench
=====================================

Name: eth_crc_frame_ctrl

Overview:
Sequencer that sits between a raw Ethernet byte stream and the combinational `crc32` core (crcIn[31:0], data[7:0] -> crcOut[31:0]).
- Hunts preamble/SFD, seeds the CRC register, and feeds each frame byte through one `crc32` instance, one byte per accepted cycle.
- Reports the final CRC register and the frame length once per frame.
- Replaces the hand-driven `crcIn = crcOut` loop with a clocked, back-pressured datapath usable by the MAC receive path.

Parameters:
PRE_LEN, 7, minimum count of consecutive 0x55 bytes required before 0xD5 (SFD)
MAX_LEN, 1514, maximum frame bytes (DA through payload); exceeding it aborts the frame
LEN_W, 11, width of the frame length counter and output
CRC_INIT, 32'hFFFFFFFF, CRC register seed loaded on SFD

Ports:
clk  in  1  single clock, all state on rising edge
rst  in  1  asynchronous, active-high reset
in_valid  in  1  in_data is valid this cycle
in_data  in  8  stream byte (preamble, SFD, frame, IFG)
in_eof  in  1  qualifies the current valid byte as the last frame byte; ignored outside DATA
in_ready  out  1  controller accepts a byte this cycle; a byte transfers when in_valid & in_ready
busy  out  1  high while in DATA
crc_valid  out  1  one-cycle pulse: crc_out/frame_len hold a completed frame result
crc_out  out  32  final CRC register of the last completed frame (raw register, no final XOR)
frame_len  out  LEN_W  byte count of the last completed frame
frame_err  out  1  one-cycle pulse: frame aborted on overflow

Behaviour:
- Reset (async, any state): state=HUNT, pre_cnt=0, crc_reg=CRC_INIT, len=0, crc_out=0, frame_len=0, crc_valid=0, frame_err=0, busy=0. in_ready=1 immediately after reset deasserts.
- States: HUNT, DATA, DONE.
- in_ready = (state != DONE). busy = (state == DATA).
- HUNT, on each accepted byte:
  - 0x55: pre_cnt = min(pre_cnt+1, PRE_LEN).
  - 0xD5 with pre_cnt==PRE_LEN: go to DATA, crc_reg=CRC_INIT, len=0, pre_cnt=0.
  - 0xD5 with pre_cnt<PRE_LEN: pre_cnt=0, stay in HUNT.
  - Any other byte: pre_cnt=0.
  - Runs of more than PRE_LEN 0x55 bytes are accepted. IFG bytes (0x00) are discarded.
- DATA, on each accepted byte:
  - crc_reg <= crc32(crc_reg, in_data); len <= len+1.
  - If in_eof: crc_out <= crc32(crc_reg, in_data), frame_len <= len+1, crc_valid <= 1, go to DONE.
  - Else if len+1 == MAX_LEN: frame_err <= 1, go to HUNT, crc_out/frame_len unchanged.
  - Bytes equal to 0x55/0xD5 inside DATA are ordinary data; no resync.
  - in_valid low: no state change, no update.
- DONE: exactly one cycle with crc_valid=1 and in_ready=0, then HUNT with pre_cnt=0.
- Latency: eof byte accepted at edge N -> crc_valid high during cycle N+1. crc_out/frame_len then hold until the next completed frame.
- crc_valid and frame_err are never high in the same cycle.
- in_eof with a byte in HUNT is ignored.
- Reset asserted mid-frame discards the partial frame with no crc_valid/frame_err pulse.
- len is LEN_W bits; MAX_LEN must be < 2^LEN_W, so no wrap occurs.

Optional Feature:
Macro ETH_LEN_CHECK_EN.
- Defined:
  - Add parameter MIN_LEN (default 60) and output port len_err (1 bit).
  - len_err is registered alongside crc_valid and is high in the crc_valid cycle iff frame_len < MIN_LEN.
  - Reset value 0; otherwise 0.
- Not defined: no MIN_LEN, no len_err port, no comparison logic. All other behaviour is identical.

Test Plan:
- 7x0x55, 0xD5, 60 random bytes, eof on the 60th -> one crc_valid pulse 1 cycle after the eof byte; frame_len=60; crc_out equals the golden model (crc32 core chained from 0xFFFFFFFF over the 60 bytes).
- Back-to-back: 35 frames with random payload 46-1500 (+14 header), IFG 12-24 zero bytes, in_valid randomly gapped -> 35 pulses; each crc_out/frame_len matches the model; in_ready low only in DONE cycles.
- 6x0x55 then 0xD5 then data -> no frame, busy stays 0. 10x0x55 then 0xD5 -> frame accepted.
- 7x0x55, 0xD5, then 1514 bytes with no eof -> frame_err pulse after byte 1514; no crc_valid; crc_out unchanged; the next valid preamble/SFD frame is processed normally.
- Reset pulsed after 20 data bytes -> all outputs 0 asynchronously; the next full frame yields the correct CRC.
- ETH_LEN_CHECK_EN defined: frames of 59 and 60 bytes -> len_err 1 and 0 respectively, coincident with crc_valid.

Source files
------------

// File: rtl/eth_crc_frame_ctrl.sv
// Ethernet receive sequencer: hunts preamble/SFD, then runs each frame byte through a CRC-32 register.
// Optional ETH_LEN_CHECK_EN adds parameter MIN_LEN and a runt-frame flag len_err alongside crc_valid.
module eth_crc_frame_ctrl #(
    parameter int unsigned PRE_LEN  = 7,
    parameter int unsigned MAX_LEN  = 1514,
    parameter int unsigned LEN_W    = 11,
    parameter logic [31:0] CRC_INIT = 32'hFFFF_FFFF
`ifdef ETH_LEN_CHECK_EN
    ,
    parameter int unsigned MIN_LEN  = 60
`endif
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [7:0]       in_data,
    input  logic             in_eof,
    output logic             in_ready,
    output logic             busy,
    output logic             crc_valid,
    output logic [31:0]      crc_out,
    output logic [LEN_W-1:0] frame_len,
    output logic             frame_err
`ifdef ETH_LEN_CHECK_EN
    ,
    output logic             len_err
`endif
);

    localparam int unsigned      PRE_W   = $clog2(PRE_LEN + 1);
    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(PRE_LEN);
    localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_LEN);

    typedef enum logic [1:0] {HUNT, DATA, DONE} state_t;

    // Reflected Ethernet CRC-32 (poly 0x04C11DB7), one byte per call, data LSB first.
    function automatic logic [31:0] crc32(input logic [31:0] crc_in, input logic [7:0] data);
        logic [31:0] c;
        c = crc_in;
        for (int i = 0; i < 8; i++) begin
            c = (c[0] ^ data[i]) ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
        end
        return c;
    endfunction

    state_t             state_q, state_d;
    logic [PRE_W-1:0]   pre_cnt_q, pre_cnt_d;
    logic [31:0]        crc_q, crc_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [31:0]        crc_out_q, crc_out_d;
    logic [LEN_W-1:0]   frame_len_q, frame_len_d;
    logic               crc_valid_q, crc_valid_d;
    logic               frame_err_q, frame_err_d;
`ifdef ETH_LEN_CHECK_EN
    logic               len_err_q, len_err_d;
`endif

    logic               accept;
    logic [31:0]        crc_next;
    logic [LEN_W-1:0]   len_inc;

    assign in_ready = (state_q != DONE);
    assign busy     = (state_q == DATA);
    assign accept   = in_valid & in_ready;
    assign crc_next = crc32(crc_q, in_data);
    assign len_inc  = len_q + LEN_W'(1);

    always_comb begin
        // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latches).
        state_d     = state_q;
        pre_cnt_d   = pre_cnt_q;
        crc_d       = crc_q;
        len_d       = len_q;
        crc_out_d   = crc_out_q;
        frame_len_d = frame_len_q;
        crc_valid_d = 1'b0;
        frame_err_d = 1'b0;
`ifdef ETH_LEN_CHECK_EN
        len_err_d   = 1'b0;
`endif
        unique case (state_q)
            HUNT: begin
                if (accept) begin
                    if (in_data == 8'h55) begin
                        if (pre_cnt_q != PRE_MAX) pre_cnt_d = pre_cnt_q + PRE_W'(1);
                    end else if (in_data == 8'hD5 && pre_cnt_q == PRE_MAX) begin
                        state_d   = DATA;
                        crc_d     = CRC_INIT;
                        len_d     = '0;
                        pre_cnt_d = '0;
                    end else begin
                        pre_cnt_d = '0;
                    end
                end
            end
            DATA: begin
                if (accept) begin
                    crc_d = crc_next;
                    len_d = len_inc;
                    // eof wins over overflow when the limit byte is also the last one.
                    if (in_eof) begin
                        crc_out_d   = crc_next;
                        frame_len_d = len_inc;
                        crc_valid_d = 1'b1;
                        state_d     = DONE;
`ifdef ETH_LEN_CHECK_EN
                        len_err_d   = (len_inc < LEN_W'(MIN_LEN));
`endif
                    end else if (len_inc == LEN_MAX) begin
                        frame_err_d = 1'b1;
                        state_d     = HUNT;
                    end
                end
            end
            DONE: begin
                state_d   = HUNT;
                pre_cnt_d = '0;
            end
            default: state_d = HUNT;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= HUNT;
            pre_cnt_q   <= '0;
            crc_q       <= CRC_INIT;
            len_q       <= '0;
            crc_out_q   <= '0;
            frame_len_q <= '0;
            crc_valid_q <= 1'b0;
            frame_err_q <= 1'b0;
`ifdef ETH_LEN_CHECK_EN
            len_err_q   <= 1'b0;
`endif
        end else begin
            // NOTE: non-blocking so every register samples the pre-edge values of the others.
            state_q     <= state_d;
            pre_cnt_q   <= pre_cnt_d;
            crc_q       <= crc_d;
            len_q       <= len_d;
            crc_out_q   <= crc_out_d;
            frame_len_q <= frame_len_d;
            crc_valid_q <= crc_valid_d;
            frame_err_q <= frame_err_d;
`ifdef ETH_LEN_CHECK_EN
            len_err_q   <= len_err_d;
`endif
        end
    end

    assign crc_valid = crc_valid_q;
    assign crc_out   = crc_out_q;
    assign frame_len = frame_len_q;
    assign frame_err = frame_err_q;
`ifdef ETH_LEN_CHECK_EN
    assign len_err   = len_err_q;
`endif

endmodule

// File: tb/tb_eth_crc_frame_ctrl.sv
// Scoreboard bench for eth_crc_frame_ctrl: a driver pushes expected frame results, a monitor pops on pulses.
// Reference CRC is a table-driven byte-wise CRC-32 built from the polynomial.
module tb_eth_crc_frame_ctrl;

    localparam int PRE_LEN = 7;
    localparam int MAX_LEN = 1514;
    localparam int LEN_W   = 11;
    localparam int MIN_LEN = 60;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic [7:0]       in_data;
    logic             in_eof;
    logic             in_ready;
    logic             busy;
    logic             crc_valid;
    logic [31:0]      crc_out;
    logic [LEN_W-1:0] frame_len;
    logic             frame_err;
`ifdef ETH_LEN_CHECK_EN
    logic             len_err;
`endif

    eth_crc_frame_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_eof    (in_eof),
        .in_ready  (in_ready),
        .busy      (busy),
        .crc_valid (crc_valid),
        .crc_out   (crc_out),
        .frame_len (frame_len),
        .frame_err (frame_err)
`ifdef ETH_LEN_CHECK_EN
        ,
        .len_err   (len_err)
`endif
    );

    typedef struct {
        bit          is_err;
        logic [31:0] crc;
        int          len;
        int          cyc;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] crc_tbl [0:255];
    int          n_cmp = 0;
    int          n_err = 0;
    int          cyc   = 0;
    bit          busy_seen = 0;
    logic [31:0] last_crc = '0;
    int          last_len = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #900000;
        $display("FAIL watchdog: simulation still running at %0t, limit 900000", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic void build_table();
        logic [31:0] c;
        for (int n = 0; n < 256; n++) begin
            c = 32'(n);
            for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
            crc_tbl[n] = c;
        end
    endfunction

    function automatic logic [31:0] model_crc(input logic [7:0] b[$]);
        logic [31:0] c;
        c = 32'hFFFF_FFFF;
        foreach (b[i]) c = crc_tbl[c[7:0] ^ b[i]] ^ (c >> 8);
        return c;
    endfunction

    // Offer one byte until accepted; optionally idle for a few cycles first.
    task automatic put(input logic [7:0] d, input logic eof, input bit gap);
        bit acc;
        int waited;
        if (gap && $urandom_range(0, 4) == 0) begin
            in_valid = 1'b0;
            in_eof   = 1'b0;
            repeat ($urandom_range(1, 3)) @(posedge clk);
            #1;
        end
        in_valid = 1'b1;
        in_data  = d;
        in_eof   = eof;
        waited   = 0;
        forever begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            if (acc) break;
            waited++;
            if (waited > 50) begin
                n_cmp++;
                n_err++;
                $display("FAIL in_ready_timeout: stalled %0d cycles, want <= 50", waited);
                break;
            end
        end
        in_valid = 1'b0;
        in_eof   = 1'b0;
    endtask

    task automatic send_ifg(input int n);
        for (int i = 0; i < n; i++) put(8'h00, 1'b0, 1'b0);
    endtask

    // Preamble + SFD + n_data bytes. The expected outcome follows from the framing rules alone.
    task automatic send_frame(input int n_pre, input int n_data, input bit eof_last,
                              input bit gaps, input bit avoid_sync);
        logic [7:0] q[$];
        logic [7:0] d;
        bit         el;
        exp_t       e;
        for (int i = 0; i < n_pre; i++) put(8'h55, 1'b0, gaps);
        put(8'hD5, 1'b0, gaps);
        for (int i = 0; i < n_data; i++) begin
            d  = avoid_sync ? 8'($urandom_range(0, 84)) : 8'($urandom);
            el = eof_last && (i == n_data - 1);
            put(d, el, gaps);
            q.push_back(d);
            if (n_pre >= PRE_LEN) begin
                if (el && i + 1 <= MAX_LEN) begin
                    e.is_err = 1'b0; e.crc = model_crc(q); e.len = i + 1; e.cyc = cyc;
                    sb.push_back(e);
                end else if (!el && i + 1 == MAX_LEN) begin
                    e.is_err = 1'b1; e.crc = '0; e.len = 0; e.cyc = cyc;
                    sb.push_back(e);
                end
            end
        end
    endtask

    // Monitor: pops one expected result per crc_valid/frame_err pulse.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (busy) busy_seen = 1'b1;
                if (in_ready == crc_valid) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL in_ready_done: in_ready=%0b crc_valid=%0b, want opposite", in_ready, crc_valid);
                end
                if (crc_valid || frame_err) begin
                    check("pulse_exclusive", {63'd0, crc_valid & frame_err}, 64'd0);
                    if (sb.size() == 0) begin
                        n_cmp++;
                        n_err++;
                        $display("FAIL unexpected_pulse: crc_valid=%0b frame_err=%0b, want none", crc_valid, frame_err);
                    end else begin
                        e = sb.pop_front();
                        check("pulse_kind_err", {63'd0, frame_err}, {63'd0, e.is_err});
                        check("pulse_cycle", 64'(cyc), 64'(e.cyc));
                        if (!e.is_err) begin
                            check("crc_out", 64'(crc_out), 64'(e.crc));
                            check("frame_len", 64'(frame_len), 64'(e.len));
`ifdef ETH_LEN_CHECK_EN
                            check("len_err", {63'd0, len_err}, {63'd0, e.len < MIN_LEN});
`endif
                            last_crc = e.crc;
                            last_len = e.len;
                        end else begin
                            check("err_crc_hold", 64'(crc_out), 64'(last_crc));
                            check("err_len_hold", 64'(frame_len), 64'(last_len));
                        end
                    end
                end
            end
        end
    end

    initial begin
        logic [7:0] ref_q[$];
        build_table();
        rst = 1'b1; in_valid = 1'b0; in_data = 8'h00; in_eof = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        check("rst_in_ready", {63'd0, in_ready}, 64'd1);
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_crc_valid", {63'd0, crc_valid}, 64'd0);
        check("rst_frame_err", {63'd0, frame_err}, 64'd0);
        check("rst_crc_out", 64'(crc_out), 64'd0);
        check("rst_frame_len", 64'(frame_len), 64'd0);
        @(posedge clk); #1;

        ref_q = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
        check("model_123456789", 64'(model_crc(ref_q)), 64'h340B_C6D9);

        // Minimal preamble, 60-byte frame.
        send_frame(7, 60, 1'b1, 1'b0, 1'b0);
        send_ifg(12);

        // Short preamble never opens a frame; eof in HUNT is ignored.
        busy_seen = 1'b0;
        send_frame(6, 20, 1'b1, 1'b0, 1'b1);
        send_ifg(12);
        check("short_pre_busy", {63'd0, busy_seen}, 64'd0);

        // Long preamble is accepted.
        send_frame(10, 64, 1'b1, 1'b1, 1'b0);
        send_ifg(12);

        // Overflow at MAX_LEN, then a normal frame.
        send_frame(7, MAX_LEN, 1'b0, 1'b0, 1'b0);
        send_ifg(12);
        send_frame(7, 100, 1'b1, 1'b1, 1'b0);
        send_ifg(12);

        // Runt boundary.
        send_frame(7, 59, 1'b1, 1'b0, 1'b0);
        send_ifg(12);
        send_frame(7, 60, 1'b1, 1'b0, 1'b0);
        send_ifg(12);

        // Reset mid-frame after 20 data bytes.
        for (int i = 0; i < 7; i++) put(8'h55, 1'b0, 1'b0);
        put(8'hD5, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) put(8'($urandom), 1'b0, 1'b0);
        #2 rst = 1'b1;
        #1;
        check("midrst_busy", {63'd0, busy}, 64'd0);
        check("midrst_crc_out", 64'(crc_out), 64'd0);
        check("midrst_frame_len", 64'(frame_len), 64'd0);
        check("midrst_crc_valid", {63'd0, crc_valid}, 64'd0);
        check("midrst_frame_err", {63'd0, frame_err}, 64'd0);
        last_crc = '0;
        last_len = 0;
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        send_frame(7, 80, 1'b1, 1'b0, 1'b0);
        send_ifg(12);

        // Back-to-back random traffic.
        for (int f = 0; f < 35; f++) begin
            send_frame(PRE_LEN + $urandom_range(0, 2), 14 + $urandom_range(46, 1500), 1'b1, 1'b1, 1'b0);
            send_ifg($urandom_range(12, 24));
        end

        repeat (5) @(posedge clk);
        #1;
        check("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
